// File: rtl/ctrl_pipeline_if.sv
// Handshake bundle between the decoder-side control pipeline and its neighbours:
// decoded controls and E-stage flags come in, stage-qualified controls go out.
interface ctrl_pipeline_if #(
    parameter int ALUCTRL_W  = 3,
    parameter int REG_ADDR_W = 5
);
    logic                  freeze_i;
    logic                  flush_e_i;
    logic                  regwrite_d_i;
    logic                  memwrite_d_i;
    logic                  jump_d_i;
    logic                  branch_d_i;
    logic                  alusrca_d_i;
    logic [1:0]            resultsrc_d_i;
    logic [1:0]            alusrcb_d_i;
    logic [ALUCTRL_W-1:0]  alucontrol_d_i;
    logic [2:0]            funct3_d_i;
    logic [REG_ADDR_W-1:0] rd_d_i;
    logic                  pred_taken_d_i;
    logic                  zero_i;
    logic                  lt_s_i;
    logic                  lt_u_i;

    logic [ALUCTRL_W-1:0]  alucontrol_e_o;
    logic                  alusrca_e_o;
    logic [1:0]            alusrcb_e_o;
    logic                  resultsrc_e_b0_o;
    logic                  regwrite_e_o;
    logic [REG_ADDR_W-1:0] rd_e_o;
    logic                  pcsrc_e_o;
    logic                  branch_taken_e_o;
    logic                  mispredict_e_o;
    logic                  predictor_we_o;
    logic                  regwrite_m_o;
    logic                  memwrite_m_o;
    logic [REG_ADDR_W-1:0] rd_m_o;
    logic                  regwrite_w_o;
    logic [1:0]            resultsrc_w_o;
    logic [REG_ADDR_W-1:0] rd_w_o;

    modport master (
        output freeze_i, flush_e_i, regwrite_d_i, memwrite_d_i, jump_d_i, branch_d_i,
               alusrca_d_i, resultsrc_d_i, alusrcb_d_i, alucontrol_d_i, funct3_d_i,
               rd_d_i, pred_taken_d_i, zero_i, lt_s_i, lt_u_i,
        input  alucontrol_e_o, alusrca_e_o, alusrcb_e_o, resultsrc_e_b0_o, regwrite_e_o,
               rd_e_o, pcsrc_e_o, branch_taken_e_o, mispredict_e_o, predictor_we_o,
               regwrite_m_o, memwrite_m_o, rd_m_o, regwrite_w_o, resultsrc_w_o, rd_w_o
    );

    modport slave (
        input  freeze_i, flush_e_i, regwrite_d_i, memwrite_d_i, jump_d_i, branch_d_i,
               alusrca_d_i, resultsrc_d_i, alusrcb_d_i, alucontrol_d_i, funct3_d_i,
               rd_d_i, pred_taken_d_i, zero_i, lt_s_i, lt_u_i,
        output alucontrol_e_o, alusrca_e_o, alusrcb_e_o, resultsrc_e_b0_o, regwrite_e_o,
               rd_e_o, pcsrc_e_o, branch_taken_e_o, mispredict_e_o, predictor_we_o,
               regwrite_m_o, memwrite_m_o, rd_m_o, regwrite_w_o, resultsrc_w_o, rd_w_o
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline D -> E -> M1..Mn -> W with freeze, E flush, a pending-flush
// latch for flushes raised while frozen, and E-stage branch resolution.
module ctrl_pipeline #(
    parameter int ALUCTRL_W  = 3,
    parameter int MEM_STAGES = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk_i,
    input  logic           reset_i,
    ctrl_pipeline_if.slave bus
);
    localparam int LAST_M = MEM_STAGES - 1;

    logic                  valid_e;
    logic                  regwrite_e;
    logic                  memwrite_e;
    logic                  jump_e;
    logic                  branch_e;
    logic                  alusrca_e;
    logic                  pred_taken_e;
    logic [1:0]            resultsrc_e;
    logic [1:0]            alusrcb_e;
    logic [ALUCTRL_W-1:0]  alucontrol_e;
    logic [2:0]            funct3_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic                  flush_pend;

    logic                  valid_m     [MEM_STAGES];
    logic                  regwrite_m  [MEM_STAGES];
    logic [1:0]            resultsrc_m [MEM_STAGES];
    logic [REG_ADDR_W-1:0] rd_m        [MEM_STAGES];
    logic                  memwrite_m1;

    logic                  valid_w;
    logic                  regwrite_w;
    logic [1:0]            resultsrc_w;
    logic [REG_ADDR_W-1:0] rd_w;

    logic                  cond;
    logic                  taken;
    logic                  bubble_e;

    assign bubble_e = bus.flush_e_i | flush_pend;

    // Execute register: a flush seen while frozen is remembered and applied on the next advance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memwrite_e   <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            alusrca_e    <= 1'b0;
            pred_taken_e <= 1'b0;
            resultsrc_e  <= '0;
            alusrcb_e    <= '0;
            alucontrol_e <= '0;
            funct3_e     <= '0;
            rd_e         <= '0;
            flush_pend   <= 1'b0;
        end else if (bus.freeze_i) begin
            if (bus.flush_e_i) begin
                flush_pend <= 1'b1;
            end
        end else begin
            flush_pend <= 1'b0;
            if (bubble_e) begin
                valid_e      <= 1'b0;
                regwrite_e   <= 1'b0;
                memwrite_e   <= 1'b0;
                jump_e       <= 1'b0;
                branch_e     <= 1'b0;
                alusrca_e    <= 1'b0;
                pred_taken_e <= 1'b0;
                resultsrc_e  <= '0;
                alusrcb_e    <= '0;
                alucontrol_e <= '0;
                funct3_e     <= '0;
                rd_e         <= '0;
            end else begin
                valid_e      <= 1'b1;
                regwrite_e   <= bus.regwrite_d_i;
                memwrite_e   <= bus.memwrite_d_i;
                jump_e       <= bus.jump_d_i;
                branch_e     <= bus.branch_d_i;
                alusrca_e    <= bus.alusrca_d_i;
                pred_taken_e <= bus.pred_taken_d_i;
                resultsrc_e  <= bus.resultsrc_d_i;
                alusrcb_e    <= bus.alusrcb_d_i;
                alucontrol_e <= bus.alucontrol_d_i;
                funct3_e     <= bus.funct3_d_i;
                rd_e         <= bus.rd_d_i;
            end
        end
    end

    // Memory and writeback shift chain; the store enable only matters in M1, so it stops there.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < MEM_STAGES; k++) begin
                valid_m[k]     <= 1'b0;
                regwrite_m[k]  <= 1'b0;
                resultsrc_m[k] <= '0;
                rd_m[k]        <= '0;
            end
            memwrite_m1 <= 1'b0;
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            resultsrc_w <= '0;
            rd_w        <= '0;
        end else if (!bus.freeze_i) begin
            valid_m[0]     <= valid_e;
            regwrite_m[0]  <= regwrite_e;
            resultsrc_m[0] <= resultsrc_e;
            rd_m[0]        <= rd_e;
            memwrite_m1    <= memwrite_e;
            for (int k = 1; k < MEM_STAGES; k++) begin
                valid_m[k]     <= valid_m[k-1];
                regwrite_m[k]  <= regwrite_m[k-1];
                resultsrc_m[k] <= resultsrc_m[k-1];
                rd_m[k]        <= rd_m[k-1];
            end
            valid_w     <= valid_m[LAST_M];
            regwrite_w  <= regwrite_m[LAST_M];
            resultsrc_w <= resultsrc_m[LAST_M];
            rd_w        <= rd_m[LAST_M];
        end
    end

    always_comb begin
        cond = 1'b0;
        case (funct3_e)
            3'b000:  cond = bus.zero_i;
            3'b001:  cond = !bus.zero_i;
            3'b100:  cond = bus.lt_s_i;
            3'b101:  cond = !bus.lt_s_i;
            3'b110:  cond = bus.lt_u_i;
            3'b111:  cond = !bus.lt_u_i;
            default: cond = 1'b0;
        endcase
    end

    assign taken = valid_e & branch_e & cond;

    // The redirect stays up through a freeze; only the predictor write is held off.
    assign bus.branch_taken_e_o = taken;
    assign bus.pcsrc_e_o        = taken | (valid_e & jump_e);
    assign bus.mispredict_e_o   = valid_e & branch_e & (cond != pred_taken_e);
    assign bus.predictor_we_o   = valid_e & branch_e & !bus.freeze_i;

    assign bus.alucontrol_e_o   = alucontrol_e;
    assign bus.alusrca_e_o      = alusrca_e;
    assign bus.alusrcb_e_o      = alusrcb_e;
    assign bus.resultsrc_e_b0_o = resultsrc_e[0];
    assign bus.regwrite_e_o     = valid_e & regwrite_e;
    assign bus.rd_e_o           = rd_e;

    assign bus.regwrite_m_o     = valid_m[0] & regwrite_m[0];
    assign bus.memwrite_m_o     = valid_m[0] & memwrite_m1;
    assign bus.rd_m_o           = rd_m[0];

    assign bus.regwrite_w_o     = valid_w & regwrite_w;
    assign bus.resultsrc_w_o    = resultsrc_w;
    assign bus.rd_w_o           = rd_w;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: two instances (MEM_STAGES=1 and 3) share one stimulus stream and
// are compared every cycle against an instruction-level pipeline model, plus directed cases.
module tb_ctrl_pipeline;
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrca;
        logic [1:0] resultsrc;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       pred_taken;
    } instr_t;

    typedef struct {
        logic [2:0] f3;
        logic       z;
        logic       ls;
        logic       lu;
        logic       taken;
    } bvec_t;

    localparam int IW = $bits(instr_t);

    logic   clk;
    logic   reset;
    logic   freeze;
    logic   flush;
    logic   zero;
    logic   lt_s;
    logic   lt_u;
    instr_t d_in;

    instr_t p1 [3];
    instr_t p3 [5];
    logic   pend;

    int tests_run;
    int fails_cnt;

    logic [31:0] act1;
    logic [31:0] act3;

    ctrl_pipeline_if bus1 ();
    ctrl_pipeline_if bus3 ();

    ctrl_pipeline #(.MEM_STAGES(1)) dut1 (.clk_i(clk), .reset_i(reset), .bus(bus1));
    ctrl_pipeline #(.MEM_STAGES(3)) dut3 (.clk_i(clk), .reset_i(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus1.freeze_i       = freeze;
        bus1.flush_e_i      = flush;
        bus1.regwrite_d_i   = d_in.regwrite;
        bus1.memwrite_d_i   = d_in.memwrite;
        bus1.jump_d_i       = d_in.jump;
        bus1.branch_d_i     = d_in.branch;
        bus1.alusrca_d_i    = d_in.alusrca;
        bus1.resultsrc_d_i  = d_in.resultsrc;
        bus1.alusrcb_d_i    = d_in.alusrcb;
        bus1.alucontrol_d_i = d_in.alucontrol;
        bus1.funct3_d_i     = d_in.funct3;
        bus1.rd_d_i         = d_in.rd;
        bus1.pred_taken_d_i = d_in.pred_taken;
        bus1.zero_i         = zero;
        bus1.lt_s_i         = lt_s;
        bus1.lt_u_i         = lt_u;
        bus3.freeze_i       = freeze;
        bus3.flush_e_i      = flush;
        bus3.regwrite_d_i   = d_in.regwrite;
        bus3.memwrite_d_i   = d_in.memwrite;
        bus3.jump_d_i       = d_in.jump;
        bus3.branch_d_i     = d_in.branch;
        bus3.alusrca_d_i    = d_in.alusrca;
        bus3.resultsrc_d_i  = d_in.resultsrc;
        bus3.alusrcb_d_i    = d_in.alusrcb;
        bus3.alucontrol_d_i = d_in.alucontrol;
        bus3.funct3_d_i     = d_in.funct3;
        bus3.rd_d_i         = d_in.rd;
        bus3.pred_taken_d_i = d_in.pred_taken;
        bus3.zero_i         = zero;
        bus3.lt_s_i         = lt_s;
        bus3.lt_u_i         = lt_u;
    end

    assign act1 = {bus1.alucontrol_e_o, bus1.alusrca_e_o, bus1.alusrcb_e_o, bus1.resultsrc_e_b0_o,
                   bus1.regwrite_e_o, bus1.rd_e_o, bus1.pcsrc_e_o, bus1.branch_taken_e_o,
                   bus1.mispredict_e_o, bus1.predictor_we_o, bus1.regwrite_m_o, bus1.memwrite_m_o,
                   bus1.rd_m_o, bus1.regwrite_w_o, bus1.resultsrc_w_o, bus1.rd_w_o};
    assign act3 = {bus3.alucontrol_e_o, bus3.alusrca_e_o, bus3.alusrcb_e_o, bus3.resultsrc_e_b0_o,
                   bus3.regwrite_e_o, bus3.rd_e_o, bus3.pcsrc_e_o, bus3.branch_taken_e_o,
                   bus3.mispredict_e_o, bus3.predictor_we_o, bus3.regwrite_m_o, bus3.memwrite_m_o,
                   bus3.rd_m_o, bus3.regwrite_w_o, bus3.resultsrc_w_o, bus3.rd_w_o};

    // Branch rule written straight from the RV32I condition list.
    function automatic logic cond_of(input logic [2:0] f3, input logic z, input logic ls, input logic lu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return ls;
            3'd5:    return !ls;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] expect_vec(input instr_t e, input instr_t m1, input instr_t w,
                                               input logic z, input logic ls, input logic lu,
                                               input logic frz);
        logic c;
        logic tk;
        c  = cond_of(e.funct3, z, ls, lu);
        tk = e.valid & e.branch & c;
        expect_vec = {e.alucontrol, e.alusrca, e.alusrcb, e.resultsrc[0], e.valid & e.regwrite,
                      e.rd, tk | (e.valid & e.jump), tk, e.valid & e.branch & (c != e.pred_taken),
                      e.valid & e.branch & !frz, m1.valid & m1.regwrite, m1.valid & m1.memwrite,
                      m1.rd, w.valid & w.regwrite, w.resultsrc, w.rd};
    endfunction

    function automatic instr_t rand_instr();
        logic [IW-1:0] raw;
        instr_t r;
        raw = IW'($urandom);
        r = raw;
        r.valid = 1'b0;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Instruction-level view: each slot is the instruction occupying that stage.
    task automatic model_edge();
        instr_t nx;
        if (reset) begin
            foreach (p1[k]) p1[k] = '0;
            foreach (p3[k]) p3[k] = '0;
            pend = 1'b0;
        end else if (freeze) begin
            if (flush) pend = 1'b1;
        end else begin
            nx = d_in;
            nx.valid = 1'b1;
            if (flush || pend) nx = '0;
            for (int k = 2; k > 0; k--) p1[k] = p1[k-1];
            for (int k = 4; k > 0; k--) p3[k] = p3[k-1];
            p1[0] = nx;
            p3[0] = nx;
            pend = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_output();
        #1;
        cmp("model_ms1", act1, expect_vec(p1[0], p1[1], p1[2], zero, lt_s, lt_u, freeze));
        cmp("model_ms3", act3, expect_vec(p3[0], p3[1], p3[4], zero, lt_s, lt_u, freeze));
    endtask

    task automatic apply_stimulus();
        reset  = (($urandom % 60) == 0);
        freeze = (($urandom % 4) == 0);
        flush  = (($urandom % 6) == 0);
        d_in   = rand_instr();
        zero   = 1'($urandom);
        lt_s   = 1'($urandom);
        lt_u   = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bvec_t      tbl [24];
        logic [2:0] taken_by_f3 [8];
        logic       zs  [3];
        logic       lss [3];
        logic       lus [3];
        int         we_count;

        // Bit s of each entry: taken for flag set s = (0,1,0), (1,0,0), (0,0,1).
        taken_by_f3[0] = 3'b010;
        taken_by_f3[1] = 3'b101;
        taken_by_f3[2] = 3'b000;
        taken_by_f3[3] = 3'b000;
        taken_by_f3[4] = 3'b001;
        taken_by_f3[5] = 3'b110;
        taken_by_f3[6] = 3'b100;
        taken_by_f3[7] = 3'b011;
        zs[0] = 1'b0; lss[0] = 1'b1; lus[0] = 1'b0;
        zs[1] = 1'b1; lss[1] = 1'b0; lus[1] = 1'b0;
        zs[2] = 1'b0; lss[2] = 1'b0; lus[2] = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 3; s++) begin
                tbl[f*3+s].f3    = 3'(f);
                tbl[f*3+s].z     = zs[s];
                tbl[f*3+s].ls    = lss[s];
                tbl[f*3+s].lu    = lus[s];
                tbl[f*3+s].taken = taken_by_f3[f][s];
            end
        end

        tests_run = 0;
        fails_cnt = 0;
        foreach (p1[k]) p1[k] = '0;
        foreach (p3[k]) p3[k] = '0;
        pend = 1'b0;

        // Reset held two edges with arbitrary inputs.
        apply_stimulus();
        reset = 1'b1;
        tick();
        apply_stimulus();
        reset = 1'b1;
        check_output();
        tick();
        apply_stimulus();
        reset = 1'b1;
        #1;
        cmp("reset_outs_ms1", act1, 32'd0);
        cmp("reset_outs_ms3", act3, 32'd0);
        reset  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        d_in   = '0;
        tick();
        check_output();
        cmp("rd_w_after_reset", 32'(bus1.rd_w_o), 32'd0);

        // Single ADD travelling to writeback.
        d_in.regwrite = 1'b1;
        d_in.rd       = 5'd7;
        for (int k = 1; k <= 6; k++) begin
            tick();
            d_in = '0;
            check_output();
            cmp("add_regwrite_w_ms1", 32'(bus1.regwrite_w_o), 32'(k == 3));
            cmp("add_rd_w_ms1", 32'(bus1.rd_w_o), (k == 3) ? 32'd7 : 32'd0);
            cmp("add_regwrite_w_ms3", 32'(bus3.regwrite_w_o), 32'(k == 5));
            cmp("add_rd_w_ms3", 32'(bus3.rd_w_o), (k == 5) ? 32'd7 : 32'd0);
        end

        // Branch matrix against the hand-written expectation table.
        for (int i = 0; i < 24; i++) begin
            d_in = '0;
            d_in.branch = 1'b1;
            d_in.funct3 = tbl[i].f3;
            tick();
            d_in = '0;
            zero = tbl[i].z;
            lt_s = tbl[i].ls;
            lt_u = tbl[i].lu;
            check_output();
            cmp($sformatf("br_taken_f%0d_s%0d", tbl[i].f3, i % 3), 32'(bus1.branch_taken_e_o), 32'(tbl[i].taken));
            cmp($sformatf("br_pcsrc_f%0d_s%0d", tbl[i].f3, i % 3), 32'(bus1.pcsrc_e_o), 32'(tbl[i].taken));
            cmp($sformatf("br_mispred_f%0d_s%0d", tbl[i].f3, i % 3), 32'(bus1.mispredict_e_o), 32'(tbl[i].taken));
        end

        // Taken BEQ held in E through three frozen cycles.
        d_in = '0;
        d_in.branch = 1'b1;
        tick();
        d_in = rand_instr();
        zero = 1'b1;
        freeze = 1'b1;
        we_count = 0;
        for (int c = 0; c < 3; c++) begin
            check_output();
            cmp("beq_frozen_pcsrc", 32'(bus1.pcsrc_e_o), 32'd1);
            cmp("beq_frozen_pred_we", 32'(bus1.predictor_we_o), 32'd0);
            we_count += int'(bus1.predictor_we_o);
            tick();
        end
        freeze = 1'b0;
        check_output();
        cmp("beq_unfrozen_pcsrc", 32'(bus1.pcsrc_e_o), 32'd1);
        cmp("beq_unfrozen_pred_we", 32'(bus1.predictor_we_o), 32'd1);
        we_count += int'(bus1.predictor_we_o);
        cmp("beq_pred_we_total", 32'(we_count), 32'd1);
        tick();

        // Two flush pulses inside one freeze window collapse into one bubble.
        d_in = '0;
        d_in.regwrite = 1'b1;
        d_in.rd = 5'd3;
        tick();
        d_in = '0;
        d_in.regwrite = 1'b1;
        d_in.rd = 5'd9;
        d_in.alucontrol = 3'd5;
        freeze = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            flush = (c == 1 || c == 3);
            check_output();
            tick();
        end
        freeze = 1'b0;
        flush  = 1'b0;
        check_output();
        cmp("frz_e_held_rd", 32'(bus1.rd_e_o), 32'd3);
        tick();
        check_output();
        cmp("frz_bubble_regwrite", 32'(bus1.regwrite_e_o), 32'd0);
        cmp("frz_bubble_rd", 32'(bus1.rd_e_o), 32'd0);
        cmp("frz_bubble_m_rd", 32'(bus1.rd_m_o), 32'd3);
        tick();
        d_in = '0;
        check_output();
        cmp("frz_next_rd", 32'(bus1.rd_e_o), 32'd9);
        cmp("frz_next_regwrite", 32'(bus1.regwrite_e_o), 32'd1);
        cmp("frz_next_alu", 32'(bus1.alucontrol_e_o), 32'd5);
        cmp("frz_m_after_bubble", 32'(bus1.rd_m_o), 32'd0);
        tick();
        check_output();
        cmp("frz_no_dup_e", 32'(bus1.rd_e_o), 32'd0);
        cmp("frz_m_next_rd", 32'(bus1.rd_m_o), 32'd9);

        // JAL redirect, then a same-edge flush replacing the following instruction.
        d_in = '0;
        d_in.jump = 1'b1;
        d_in.regwrite = 1'b1;
        d_in.rd = 5'd1;
        tick();
        d_in = '0;
        d_in.regwrite = 1'b1;
        d_in.rd = 5'd5;
        flush = 1'b1;
        check_output();
        cmp("jal_pcsrc", 32'(bus1.pcsrc_e_o), 32'd1);
        cmp("jal_mispredict", 32'(bus1.mispredict_e_o), 32'd0);
        tick();
        flush = 1'b0;
        d_in = '0;
        check_output();
        cmp("jal_flush_regwrite", 32'(bus1.regwrite_e_o), 32'd0);
        cmp("jal_flush_rd", 32'(bus1.rd_e_o), 32'd0);

        // Randomized traffic with freeze, flush and occasional reset.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus();
            check_output();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails_cnt);
        $finish;
    end
endmodule
